// File: rtl/ddram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddram_loader_pkg
// Description : Shared types for the DDR3 byte-port loader: FSM state
//               encoding, request source and the download FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
package ddram_loader_pkg;

    localparam int c_ADDR_W = 29;
    localparam int c_DATA_W = 8;

    // Byte-port handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Which requester owns the transaction in flight
    typedef enum logic [0:0] {
        SRC_FIFO = 1'b0,
        SRC_CPU  = 1'b1
    } src_t;

    // One buffered download byte with its destination address
    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/ddram_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddram_loader_fifo
// Description : Synchronous FIFO for download bytes. Pointers carry one extra
//               wrap bit so full and empty are told apart without a counter.
//               Head entry is presented combinationally (show-ahead).
// Revision    : 1.0 - initial release
// ============================================================================
module ddram_loader_fifo
    import ddram_loader_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  fifo_entry_t             i_push_data,
    input  logic                    i_pop,
    output fifo_entry_t             o_pop_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_free
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    fifo_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   w_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_full     = (w_count == c_PTR_W'(DEPTH));
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_free     = c_PTR_W'(DEPTH) - w_count;
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[c_IDX_W-1:0]];

    // Advance pointers; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ddram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ddram_loader
// Description : Feeds the 8-bit DDR3 byte port from the HPS ioctl download
//               stream (buffered in a FIFO) and a single-request CPU port.
//               Each request becomes a level strobe held until ready falls,
//               then released until ready returns.
// Options     : DDRAM_LOADER_CHECKSUM_EN adds checksum[15:0], the mod-2^16
//               sum of download bytes committed to memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ddram_loader
    import ddram_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int WAIT_SLACK = 2
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [28:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic [28:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_busy,
    output logic [28:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready,
    output logic        load_done,
    output logic        overflow
`ifdef DDRAM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int c_FREE_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    fifo_entry_t          w_push_data;
    fifo_entry_t          w_head;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_fifo_pop;
    logic [c_FREE_W-1:0]  w_fifo_free;

    // Handshake FSM
    state_t       r_state, w_state_nxt;
    src_t         r_src, w_src_nxt;
    logic [28:0]  r_mem_addr, w_mem_addr_nxt;
    logic [7:0]   r_mem_din, w_mem_din_nxt;
    logic         r_mem_we, w_mem_we_nxt;
    logic         r_mem_rd, w_mem_rd_nxt;
    logic [7:0]   r_cpu_dout, w_cpu_dout_nxt;
    logic         w_commit;

    // CPU request latch
    logic         r_cpu_busy;
    logic [28:0]  r_cpu_addr;
    logic [7:0]   r_cpu_din;
    logic         r_cpu_is_rd;
    logic         w_cpu_accept;

    // Download session tracking
    logic         r_dl_d;
    logic         w_dl_rise;
    logic         w_dl_fall;
    logic         r_ioctl_wait;
    logic         r_overflow;
    logic         r_load_armed;
    logic         r_load_done;

    assign w_push_data  = {ioctl_addr, ioctl_dout};
    assign w_dl_rise    = ioctl_download && !r_dl_d;
    assign w_dl_fall    = !ioctl_download && r_dl_d;
    assign w_cpu_accept = (cpu_we || cpu_rd) && !r_cpu_busy;

    ddram_loader_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (DDRAM_CLK),
        .rst         (reset),
        .i_push      (ioctl_wr),
        .i_push_data (w_push_data),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_free      (w_fifo_free)
    );

    // FSM state and registered byte-port outputs
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_src      <= SRC_FIFO;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_cpu_dout <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_src      <= w_src_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_cpu_dout <= w_cpu_dout_nxt;
        end
    end

    // Arbitration in IDLE (FIFO first), strobe release on ready low, completion on ready high
    always_comb begin
        w_state_nxt    = r_state;
        w_src_nxt      = r_src;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_we_nxt   = r_mem_we;
        w_mem_rd_nxt   = r_mem_rd;
        w_cpu_dout_nxt = r_cpu_dout;
        w_fifo_pop     = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_src_nxt      = SRC_FIFO;
                    w_mem_addr_nxt = w_head.addr;
                    w_mem_din_nxt  = w_head.data;
                    w_mem_we_nxt   = 1'b1;
                    w_fifo_pop     = 1'b1;
                    w_state_nxt    = ST_ISSUE;
                end else if (r_cpu_busy) begin
                    w_src_nxt      = SRC_CPU;
                    w_mem_addr_nxt = r_cpu_addr;
                    w_mem_din_nxt  = r_cpu_din;
                    w_mem_we_nxt   = !r_cpu_is_rd;
                    w_mem_rd_nxt   = r_cpu_is_rd;
                    w_state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mem_ready) begin
                    w_mem_we_nxt = 1'b0;
                    w_mem_rd_nxt = 1'b0;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_commit = 1'b1;
                    if (r_src == SRC_CPU && r_cpu_is_rd) w_cpu_dout_nxt = mem_dout;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_mem_we_nxt = 1'b0;
                w_mem_rd_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // CPU request latch: write beats read, pulses while busy are dropped
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_cpu_busy  <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_din   <= '0;
            r_cpu_is_rd <= 1'b0;
        end else if (w_cpu_accept) begin
            r_cpu_busy  <= 1'b1;
            r_cpu_addr  <= cpu_addr;
            r_cpu_din   <= cpu_din;
            r_cpu_is_rd <= !cpu_we;
        end else if (w_commit && r_src == SRC_CPU) begin
            r_cpu_busy  <= 1'b0;
        end
    end

    // Flow control and sticky drop flag for the download stream
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_dl_d       <= 1'b0;
            r_ioctl_wait <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_dl_d       <= ioctl_download;
            r_ioctl_wait <= (w_fifo_free <= c_FREE_W'(WAIT_SLACK));
            if (ioctl_wr && w_fifo_full) r_overflow <= 1'b1;
            else if (w_dl_rise)          r_overflow <= 1'b0;
        end
    end

    // End-of-download pulse once the last buffered byte has reached memory
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_load_armed <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (w_dl_rise) begin
                r_load_armed <= 1'b0;
            end else if (w_dl_fall) begin
                r_load_armed <= 1'b1;
            end else if (r_load_armed && w_fifo_empty && r_state == ST_IDLE) begin
                r_load_armed <= 1'b0;
                r_load_done  <= 1'b1;
            end
        end
    end

`ifdef DDRAM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Sum of download bytes as each one completes on the byte port
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_dl_rise) begin
            r_checksum <= '0;
        end else if (w_commit && r_src == SRC_FIFO) begin
            r_checksum <= r_checksum + {8'h00, r_mem_din};
        end
    end

    assign checksum = r_checksum;
`endif

    assign ioctl_wait = r_ioctl_wait;
    assign overflow   = r_overflow;
    assign load_done  = r_load_done;
    assign cpu_busy   = r_cpu_busy;
    assign cpu_dout   = r_cpu_dout;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign mem_we     = r_mem_we;
    assign mem_rd     = r_mem_rd;

endmodule
`default_nettype wire
